// File: rtl/icache_s2.sv
// Instruction cache stage 2: tag compare, way select, and the miss/uncached refill FSM.
// Hit data is returned combinationally; misses stall stage 1 until the bus delivers the word.
module icache_s2 (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         s2_rreq_i,
    input  logic         s2_cached_i,
    input  logic [31:0]  s2_virtual_addr_i,
    input  logic [31:0]  s2_physical_addr_i,
    input  logic [20:0]  s2_tagv_w0_i,
    input  logic [20:0]  s2_tagv_w1_i,
    input  logic         s2_valid0_i,
    input  logic         s2_valid1_i,
    input  logic [31:0]  s2_data_way0_i,
    input  logic [31:0]  s2_data_way1_i,
    input  logic         axi_arready_i,
    input  logic         axi_rend_i,
    input  logic [255:0] axi_rdata_i,
    output logic         s2_hit1_o,
    output logic         s2_hit2_o,
    output logic         s2_rreq_o,
    output logic [1:0]   s2_status_o,
    output logic         icache_stall_o,
    output logic         axi_rreq_o,
    output logic [31:0]  axi_raddr_o,
    output logic         axi_uncached_o,
    output logic         inst_valid_o,
    output logic [31:0]  inst_o,
    output logic [31:0]  inst_addr_o
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_READ  = 2'b01,
        S_UREAD = 2'b10,
        S_RESP  = 2'b11
    } state_t;

    state_t        r_state;
    logic          r_issued;
    logic [31:0]   r_word;

    logic          w_hit0;
    logic          w_hit1;
    logic          w_hit_any;
    logic          w_idle;
    logic          w_busy;
    logic          w_rend_ok;
    logic [7:0][31:0] w_line;

    assign w_line    = axi_rdata_i;
    assign w_hit0    = s2_rreq_i & s2_cached_i & s2_valid0_i
                       & (s2_tagv_w0_i == s2_physical_addr_i[31:11]);
    assign w_hit1    = s2_rreq_i & s2_cached_i & s2_valid1_i
                       & (s2_tagv_w1_i == s2_physical_addr_i[31:11]);
    assign w_hit_any = w_hit0 | w_hit1;
    assign w_idle    = (r_state == S_IDLE);
    assign w_busy    = (r_state == S_READ) | (r_state == S_UREAD);
    // A read-end before the address handshake belongs to an abandoned transfer.
    assign w_rend_ok = w_busy & r_issued & axi_rend_i;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_issued <= 1'b0;
            r_word   <= 32'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_issued <= 1'b0;
                    if (s2_rreq_i && !w_hit_any)
                        r_state <= s2_cached_i ? S_READ : S_UREAD;
                end
                S_READ, S_UREAD: begin
                    if (!r_issued && axi_arready_i)
                        r_issued <= 1'b1;
                    if (w_rend_ok) begin
                        r_word   <= (r_state == S_READ) ? w_line[s2_physical_addr_i[4:2]]
                                                        : w_line[0];
                        r_issued <= 1'b0;
                        r_state  <= S_RESP;
                    end
                end
                S_RESP:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Hits only reported in IDLE so the LRU in stage 1 is updated once per access.
    assign s2_hit1_o      = w_idle & w_hit0;
    assign s2_hit2_o      = w_idle & w_hit1;
    assign s2_rreq_o      = s2_rreq_i & s2_cached_i;
    assign s2_status_o    = r_state;
    assign icache_stall_o = w_busy | (w_idle & s2_rreq_i & ~w_hit_any);

    assign axi_rreq_o     = w_busy & ~r_issued;
    assign axi_uncached_o = (r_state == S_UREAD);
    assign axi_raddr_o    = (r_state == S_READ) ? {s2_physical_addr_i[31:5], 5'b0}
                                                : s2_physical_addr_i;

    assign inst_valid_o   = (w_idle & w_hit_any) | (r_state == S_RESP);
    assign inst_o         = (r_state == S_RESP) ? r_word
                          : (w_hit0 ? s2_data_way0_i : s2_data_way1_i);
    assign inst_addr_o    = s2_virtual_addr_i;

endmodule
